// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder emulating a 12-bit serial ADC: takes a command, returns a sample.
// Define SPI_RESP_STARTBIT_EN to reject commands whose first (start) bit is 0.
module spi_adc_responder #(
  parameter int unsigned CMD_BITS    = 8,
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cs_i,
  input  logic                 dclk_i,
  input  logic                 mosi_i,
  output logic                 miso_o,
  input  logic [DATA_BITS-1:0] sample_i,
  output logic [CMD_BITS-1:0]  cmd_o,
  output logic                 cmd_valid_o,
  output logic                 frame_done_o
);

  localparam int unsigned TotalBits = CMD_BITS + DATA_BITS;
  localparam int unsigned CntW      = $clog2(TotalBits + 1);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StTail} state_e;

  logic [SYNC_STAGES-1:0] cs_sync, dclk_sync, mosi_sync;
  logic                   cs_prev, dclk_prev;
  logic                   cs_rise_q, cs_fall_q, dclk_rise_q, dclk_fall_q, mosi_q;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [CMD_BITS-2:0]    cmd_sh_q, cmd_sh_d;
  logic [DATA_BITS-1:0]   data_sh_q, data_sh_d;
  logic [CMD_BITS-1:0]    cmd_q, cmd_d;
  logic                   miso_q, miso_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic [CMD_BITS-1:0]    cmd_word;
  logic                   cmd_ok;

  // Edge pulses are registered one stage past the synchronizer; mosi travels alongside.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_sync     <= '0;
      dclk_sync   <= '0;
      mosi_sync   <= '0;
      cs_prev     <= 1'b0;
      dclk_prev   <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      dclk_rise_q <= 1'b0;
      dclk_fall_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_i};
      dclk_sync   <= {dclk_sync[SYNC_STAGES-2:0], dclk_i};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      cs_prev     <= cs_sync[SYNC_STAGES-1];
      dclk_prev   <= dclk_sync[SYNC_STAGES-1];
      cs_rise_q   <= cs_sync[SYNC_STAGES-1] & ~cs_prev;
      cs_fall_q   <= ~cs_sync[SYNC_STAGES-1] & cs_prev;
      dclk_rise_q <= dclk_sync[SYNC_STAGES-1] & ~dclk_prev;
      dclk_fall_q <= ~dclk_sync[SYNC_STAGES-1] & dclk_prev;
      mosi_q      <= mosi_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cmd_sh_q     <= '0;
      data_sh_q    <= '0;
      cmd_q        <= '0;
      miso_q       <= 1'b0;
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_sh_q     <= cmd_sh_d;
      data_sh_q    <= data_sh_d;
      cmd_q        <= cmd_d;
      miso_q       <= miso_d;
      cmd_valid_q  <= cmd_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cmd_word = {cmd_sh_q, mosi_q};

`ifdef SPI_RESP_STARTBIT_EN
  assign cmd_ok = cmd_word[CMD_BITS-1];
`else
  assign cmd_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_sh_d     = cmd_sh_q;
    data_sh_d    = data_sh_q;
    cmd_d        = cmd_q;
    miso_d       = miso_q;
    cmd_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    // A chip-select release takes priority over any dclk edge in the same cycle.
    if (cs_rise_q) begin
      state_d      = StIdle;
      cnt_d        = '0;
      miso_d       = 1'b0;
      frame_done_d = (state_q == StTail);
    end else begin
      unique case (state_q)
        StIdle: begin
          miso_d   = 1'b0;
          cnt_d    = '0;
          cmd_sh_d = '0;
          if (cs_fall_q) state_d = StCmd;
        end
        StCmd: begin
          if (dclk_rise_q) begin
            cmd_sh_d = cmd_word[CMD_BITS-2:0];
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == CntW'(CMD_BITS - 1)) begin
              if (cmd_ok) begin
                cmd_d       = cmd_word;
                cmd_valid_d = 1'b1;
                data_sh_d   = sample_i;
                state_d     = StData;
              end else begin
                state_d = StTail;
              end
            end
          end
        end
        StData: begin
          if (dclk_fall_q) begin
            miso_d    = data_sh_q[DATA_BITS-1];
            data_sh_d = {data_sh_q[DATA_BITS-2:0], 1'b0};
          end
          if (dclk_rise_q) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(TotalBits - 1)) state_d = StTail;
          end
        end
        StTail: begin
          if (dclk_fall_q) miso_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign miso_o       = miso_q;
  assign cmd_o        = cmd_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Scoreboard bench for spi_adc_responder: a reader model drives frames, a monitor checks pulses.
module tb_spi_adc_responder;

  localparam int Half = 8;  // dclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, dclk, mosi;
  logic        miso;
  logic [11:0] sample;
  logic [7:0]  cmd;
  logic        cmd_valid, frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_cmd_q[$];
  int         exp_done = 0;

  spi_adc_responder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cs_i        (cs),
    .dclk_i      (dclk),
    .mosi_i      (mosi),
    .miso_o      (miso),
    .sample_i    (sample),
    .cmd_o       (cmd),
    .cmd_valid_o (cmd_valid),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match an expectation queued by the stimulus.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        n_tests++;
        if (exp_cmd_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_cmd_valid: got cmd 0x%0h expected no pulse", cmd);
        end else begin
          logic [7:0] e;
          e = exp_cmd_q.pop_front();
          if (cmd !== e) begin
            n_fail++;
            $display("FAIL cmd_value: got 0x%0h expected 0x%0h", cmd, e);
          end
        end
      end
      if (frame_done) begin
        n_tests++;
        if (exp_done == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame_done: got pulse expected none");
        end else begin
          exp_done--;
        end
      end
    end
  end

  task automatic frame(input logic [7:0] c, input int nclk, input bit end_cs,
                       output logic [31:0] bits);
    bits = '0;
    @(negedge clk) cs = 1'b0;
    repeat (Half) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      mosi = (i < 8) ? c[7-i] : 1'b0;
      repeat (Half) @(negedge clk);
      dclk = 1'b1;
      bits = {bits[30:0], miso};
      repeat (Half) @(negedge clk);
      dclk = 1'b0;
    end
    if (end_cs) begin
      repeat (Half) @(negedge clk);
      cs = 1'b1;
      repeat (12) @(negedge clk);
    end
  endtask

  task automatic check_drained(input string name);
    check({name, "_pending_cmd"}, exp_cmd_q.size(), 0);
    check({name, "_pending_done"}, exp_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bits;
    rst = 1'b1; cs = 1'b1; dclk = 1'b0; mosi = 1'b0; sample = 12'h000;
    repeat (3) @(negedge clk);
    check("reset_miso", miso, 0);
    check("reset_cmd", cmd, 0);
    check("reset_cmd_valid", cmd_valid, 0);
    check("reset_frame_done", frame_done, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Normal read
    sample = 12'hABC;
    exp_cmd_q.push_back(8'h97); exp_done++;
    frame(8'h97, 20, 1'b1, bits);
    check("normal_read", bits[19:0], 20'h00ABC);
    check_drained("normal");

    // Extra clocks
    sample = 12'hFFF;
    exp_cmd_q.push_back(8'h97); exp_done++;
    frame(8'h97, 24, 1'b1, bits);
    check("extra_clocks", bits[23:0], 24'h00FFF0);
    check_drained("extra");

    // Abort in CMD
    sample = 12'h5A3;
    frame(8'h3C, 5, 1'b1, bits);
    check("abort_cmd_kept", cmd, 8'h97);
    check("abort_miso", miso, 0);
    check_drained("abort");
    exp_cmd_q.push_back(8'h97); exp_done++;
    frame(8'h97, 20, 1'b1, bits);
    check("after_abort_read", bits[19:0], 20'h005A3);
    check_drained("after_abort");

    // Sample changes shortly after latch
    sample = 12'h123;
    exp_cmd_q.push_back(8'h97); exp_done++;
    fork
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
          @(negedge clk);
          if (cmd_valid) seen = 1'b1;
        end
        if (!seen) check("swap_wait_cmd_valid", 0, 1);
        repeat (2) @(negedge clk);
        sample = 12'hFED;
      end
    join_none
    frame(8'h97, 20, 1'b1, bits);
    check("sample_stability", bits[19:0], 20'h00123);
    check_drained("stability");

    // Reset mid-DATA
    sample = 12'h777;
    exp_cmd_q.push_back(8'h97);
    frame(8'h97, 12, 1'b0, bits);
    @(negedge clk) rst = 1'b1;
    #1;
    check("midreset_miso", miso, 0);
    check("midreset_cmd", cmd, 0);
    check("midreset_cmd_valid", cmd_valid, 0);
    check("midreset_frame_done", frame_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; cs = 1'b1;
    repeat (12) @(negedge clk);
    check_drained("midreset");
    sample = 12'h3C5;
    exp_cmd_q.push_back(8'h97); exp_done++;
    frame(8'h97, 20, 1'b1, bits);
    check("after_reset_read", bits[19:0], 20'h003C5);
    check_drained("after_reset");

    // Start-bit handling
    sample = 12'h6E1;
`ifdef SPI_RESP_STARTBIT_EN
    exp_done++;
    frame(8'h17, 20, 1'b1, bits);
    check("startbit_reject_read", bits[19:0], 20'h00000);
    check("startbit_reject_cmd", cmd, 8'h97);
`else
    exp_cmd_q.push_back(8'h17); exp_done++;
    frame(8'h17, 20, 1'b1, bits);
    check("no_startbit_read", bits[19:0], 20'h006E1);
`endif
    check_drained("startbit");
    exp_cmd_q.push_back(8'h97); exp_done++;
    frame(8'h97, 20, 1'b1, bits);
    check("final_read", bits[19:0], 20'h006E1);
    check_drained("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

SPI responder that emulates the 12-bit serial ADC read by the team's SPI reader block, so that reader can be exercised on-board and in simulation without the physical converter. It runs entirely in the `clk_i` domain. It oversamples the incoming `cs`, `dclk` and `mosi` lines, captures the 8-bit command, and shifts back a 12-bit sample taken from a parallel input. It sits at the board pins in place of the ADC, or in the testbench facing the reader.

## Interface
- `CMD_BITS`, 8, command length shifted in on `mosi_i`
- `DATA_BITS`, 12, result length shifted out on `miso_o`
- `SYNC_STAGES`, 2, synchronizer depth on `cs_i`, `dclk_i`, `mosi_i` (minimum 2)

Ports:
- `clk_i`  in  1  system clock
- `rst_i`  in  1  asynchronous, active-high reset
- `cs_i`  in  1  chip select, active low, asynchronous to `clk_i`
- `dclk_i`  in  1  serial clock from the reader, asynchronous to `clk_i`
- `mosi_i`  in  1  command data from the reader
- `miso_o`  out  1  result data to the reader
- `sample_i`  in  `DATA_BITS`  value returned in the current frame
- `cmd_o`  out  `CMD_BITS`  last accepted command, held until the next accepted command
- `cmd_valid_o`  out  1  one-cycle pulse when `cmd_o` updates
- `frame_done_o`  out  1  one-cycle pulse at `cs_i` deassertion after a complete frame (`CMD_BITS`+`DATA_BITS` rising edges)

## Operation
- Serial mode 0: the reader changes `mosi_i` on falling `dclk_i` and samples `miso_o` on rising `dclk_i`. The responder samples `mosi_i` on rising edges and updates `miso_o` on falling edges. Bit order is MSB first in both directions.
- Edges are detected on the synchronized `dclk_i`. The `mosi_i` value is taken from the same synchronizer stage as the `dclk_i` edge detection.
- State machine (`IDLE`, `CMD`, `DATA`, `TAIL`):
  - `IDLE`: `miso_o`=0 and the bit counter is cleared. A synchronized falling edge of `cs_i` moves to `CMD`.
  - `CMD`: each rising edge shifts `mosi_i` into the command register.
    - On rising edge `CMD_BITS`: `cmd_o` loads, `cmd_valid_o` pulses, `sample_i` is latched into the output shift register, and the state moves to `DATA`.
  - `DATA`: each falling edge drives the next result bit on `miso_o`. The first falling edge after entering `DATA` drives bit `DATA_BITS`-1.
    - After rising edge `CMD_BITS`+`DATA_BITS`, move to `TAIL`.
  - `TAIL`: `miso_o` is driven 0 on every further falling edge. Extra clocks are tolerated.
- A synchronized rising edge of `cs_i` returns the block to `IDLE` from any state. `miso_o` is cleared the same cycle.
  - `frame_done_o` pulses only if the state was `TAIL`.
  - A deassertion in `CMD` discards the partial command: no `cmd_valid_o`, and `cmd_o` is unchanged.
- `sample_i` is sampled once per frame only. Changes to `sample_i` after the latch do not affect the frame in progress.
- `dclk_i` edges while `cs_i` is synchronized high are ignored.

## Timing
- Reset values: `miso_o`=0, `cmd_o`=0, `cmd_valid_o`=0, `frame_done_o`=0, state `IDLE`, all counters and shift registers 0.
- Pin-to-detection latency is `SYNC_STAGES`+1 cycles.
  - `miso_o` changes exactly `SYNC_STAGES`+2 `clk_i` cycles after a `dclk_i` falling edge at the pin.
  - `cmd_valid_o` is asserted `SYNC_STAGES`+2 cycles after rising edge `CMD_BITS` at the pin.
- Required reader timing:
  - `dclk_i` high and low phases each ≥ `SYNC_STAGES`+3 `clk_i` cycles.
  - `cs_i` falling edge precedes the first `dclk_i` rising edge by ≥ `SYNC_STAGES`+2 cycles.
  - `cs_i` high time between frames is ≥ `SYNC_STAGES`+2 cycles.
- Simultaneous synchronized `cs_i` rising edge and `dclk_i` edge in the same cycle: the `cs_i` rising edge wins, and the `dclk_i` edge is dropped.
- Reset mid-frame forces the reset values immediately, with no pulses. The next frame starts only on a fresh `cs_i` falling edge.

## Configuration
- `SPI_RESP_STARTBIT_EN` defined: command bit `CMD_BITS`-1 is the start bit.
  - If it is 0 at rising edge `CMD_BITS`, the command is rejected: no `cmd_valid_o`, `cmd_o` is unchanged, and the state moves to `TAIL`, so `miso_o` stays 0 for the rest of the frame. `frame_done_o` still pulses at `cs_i` deassertion.
- Not defined: every complete command is accepted.

## Test plan
- Normal read: `sample_i`=12'hABC, reader sends 8'b10010111 with 20 clocks.
  - Required: `cmd_o`=8'h97 with a single `cmd_valid_o` pulse.
  - The reader captures 12'hABC, i.e. the `miso_o` sequence 1010_1011_1100.
  - One `frame_done_o` pulse follows `cs_i` high.
- Extra clocks: 24 `dclk_i` cycles with `sample_i`=12'hFFF → bits 9–20 are all 1, and bits 21–24 read 0.
- Abort in `CMD`: `cs_i` goes high after 5 clocks → no `cmd_valid_o`, no `frame_done_o`, and `cmd_o` keeps its previous value. `miso_o`=0. The next full frame with 8'h97 reads correctly.
- Sample stability: `sample_i` changes from 12'h123 to 12'hFED two cycles after `cmd_valid_o` → the reader still captures 12'h123.
- Reset mid-`DATA` (after 12 clocks) → all outputs are 0 the cycle reset is asserted. A subsequent frame returns the current `sample_i` correctly.
- With `SPI_RESP_STARTBIT_EN`: command 8'h17 → no `cmd_valid_o`, `miso_o` stays 0 for all 20 clocks, and `frame_done_o` pulses. Command 8'h97 is then accepted normally.
